tdm_demux_1_n: RTL and testbench
================================

Name: tdm_demux_1_n

Overview:
- Time-division demultiplexer: receives one word per valid beat on a single serial data lane and distributes successive words to NUM_CHANNELS registered output channels.
- Slot order is set by a frame-sync marker.
- Receive-side counterpart of the team's N:1 multiplexer blocks; sits at the far end of a shared TDM link and rebuilds the per-channel parallel data.

Parameters:
- DATA_WIDTH, 8, width of each data word and each channel.
- NUM_CHANNELS, 4, slots per frame; legal range 2..16.

Ports:
- Clock_In  input  1  clock; all state updates on rising edge.
- Reset_N_In  input  1  asynchronous, active-low reset.
- Enable_In  input  1  block enable; when low, input beats are ignored and all state holds.
- Clear_Error_In  input  1  synchronous clear of the sticky error flag.
- Data_Valid_In  input  1  Data_In/Frame_Sync_In carry a beat this cycle.
- Frame_Sync_In  input  1  qualified by Data_Valid_In; marks the beat as slot 0.
- Data_In  input  DATA_WIDTH  serial TDM word.
- Channel_Data_Out  output  NUM_CHANNELS*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- Channel_Valid_Out  output  NUM_CHANNELS  one-cycle pulse on bit k when channel k is updated.
- Frame_Done_Out  output  1  one-cycle pulse when the last slot of a frame is written.
- Locked_Out  output  1  high in LOCKED state.
- Slot_Out  output  $clog2(NUM_CHANNELS)  next slot index expected.
- Sync_Error_Out  output  1  sticky framing-error flag.

Behaviour:
- Reset (async assert, sync release): state=HUNT, slot=0, every channel register=0, Channel_Valid_Out=0, Frame_Done_Out=0, Locked_Out=0, Slot_Out=0, Sync_Error_Out=0.
- Beat = rising edge with Enable_In=1 and Data_Valid_In=1. Non-beat cycles: channel data holds; Channel_Valid_Out and Frame_Done_Out are 0.
- Latency: a beat sampled at edge N appears on Channel_Data_Out and Channel_Valid_Out after edge N (one registered stage). There is no backpressure.
- HUNT:
  - Beat without sync is discarded.
  - Beat with sync: write channel 0, slot=1, go to LOCKED.
- LOCKED, beat at slot s:
  - Sync=0 and s!=0: write channel s, slot=s+1.
  - Sync=1 and s==0: write channel 0, slot=1. This is normal frame start.
  - Sync=1 and s!=0 (early sync): set Sync_Error_Out, write channel 0, slot=1, stay LOCKED. No Frame_Done_Out.
  - Sync=0 and s==0 (missing sync): set Sync_Error_Out, discard beat, go to HUNT.
- Wrap: a write to slot NUM_CHANNELS-1 sets slot=0 and pulses Frame_Done_Out in the same cycle as that channel's Channel_Valid_Out.
- Enable_In low: no writes, state and slot frozen, pulses 0. Frames resume at the held slot.
- Clear_Error_In=1: Sync_Error_Out=0 next edge. If an error event occurs in the same cycle, the error wins and the flag stays 1.
- Reset mid-frame: immediate return to reset values. Partially received frames are lost.

Optional Feature:
- Macro TDM_DEMUX_ERR_COUNT_EN.
- Defined: adds output Error_Count_Out[7:0].
  - Reset value 0.
  - Increments by 1 per sync-error event (early or missing sync).
  - Saturates at 255.
  - Cleared by Clear_Error_In. If an error event coincides with Clear_Error_In, the count becomes 1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then 2 frames of beats (sync on slot 0) with data 0x10,0x11,0x12,0x13,0x20..0x23 -> channels read 0x20,0x21,0x22,0x23; Frame_Done_Out pulses twice; Locked_Out=1; Sync_Error_Out=0.
- Beats 0xAA,0xBB with no sync after reset -> discarded; Locked_Out=0; Channel_Valid_Out never set; Sync_Error_Out=0.
- Locked; sync asserted on slot 2 with data 0x55 -> channel 0=0x55, Slot_Out=1, Sync_Error_Out=1, no Frame_Done_Out. With macro defined, Error_Count_Out=1.
- Locked at slot 0; beat without sync -> Locked_Out=0, Sync_Error_Out=1, channel data unchanged. Then Clear_Error_In -> Sync_Error_Out=0.
- Mid-frame (slot 2): Enable_In low for 3 cycles while Data_Valid_In=1 -> no updates, Slot_Out stays 2. Re-enable; beats 0x33,0x44 land in channels 2,3; Frame_Done_Out pulses on the 0x44 write.
- Assert Reset_N_In low asynchronously mid-cycle at slot 3 -> all outputs 0 immediately; state HUNT after release.

Source files
------------

// File: rtl/tdm_demux_1_n.sv
// 1:N time-division demultiplexer: frame-sync aligned slot counter steering serial words into registered channels.
// Optional per-event sync-error counter enabled by defining TDM_DEMUX_ERR_COUNT_EN.
module tdm_demux_1_n #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_CHANNELS = 4
) (
  input  logic                               Clock_In,
  input  logic                               Reset_N_In,
  input  logic                               Enable_In,
  input  logic                               Clear_Error_In,
  input  logic                               Data_Valid_In,
  input  logic                               Frame_Sync_In,
  input  logic [DATA_WIDTH-1:0]              Data_In,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Channel_Data_Out,
  output logic [NUM_CHANNELS-1:0]            Channel_Valid_Out,
  output logic                               Frame_Done_Out,
  output logic                               Locked_Out,
  output logic [$clog2(NUM_CHANNELS)-1:0]    Slot_Out,
`ifdef TDM_DEMUX_ERR_COUNT_EN
  output logic [7:0]                         Error_Count_Out,
`endif
  output logic                               Sync_Error_Out
);

  localparam int unsigned SW = $clog2(NUM_CHANNELS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CHANNELS - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                             state_q, state_d;
  logic [SW-1:0]                      slot_q, slot_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_CHANNELS-1:0]            valid_q, valid_d;
  logic                               done_q, done_d;
  logic                               err_q, err_d;
  logic                               beat;
  logic                               write_en;
  logic [SW-1:0]                      write_slot;
  logic                               err_event;

  assign beat = Enable_In & Data_Valid_In;

  // Slot decision: which channel (if any) takes this beat, and framing errors.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    write_en   = 1'b0;
    write_slot = '0;
    err_event  = 1'b0;
    done_d     = 1'b0;
    if (beat) begin
      unique case (state_q)
        HUNT: begin
          if (Frame_Sync_In) begin
            write_en = 1'b1;
            slot_d   = SW'(1);
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          if (Frame_Sync_In) begin
            // Early sync realigns to slot 0 without completing the frame.
            err_event = (slot_q != '0);
            write_en  = 1'b1;
            slot_d    = SW'(1);
          end else if (slot_q == '0) begin
            err_event = 1'b1;
            state_d   = HUNT;
          end else begin
            write_en   = 1'b1;
            write_slot = slot_q;
            if (slot_q == LAST_SLOT) begin
              slot_d = '0;
              done_d = 1'b1;
            end else begin
              slot_d = slot_q + SW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = '0;
    if (write_en) begin
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        if (write_slot == SW'(k)) begin
          data_d[k*DATA_WIDTH +: DATA_WIDTH] = Data_In;
          valid_d[k]                         = 1'b1;
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_event) begin
      err_d = 1'b1;
    end else if (Clear_Error_In) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q <= HUNT;
      slot_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef TDM_DEMUX_ERR_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (err_event) begin
      if (Clear_Error_In) begin
        cnt_d = 8'd1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (Clear_Error_In) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Error_Count_Out = cnt_q;
`endif

  assign Channel_Data_Out  = data_q;
  assign Channel_Valid_Out = valid_q;
  assign Frame_Done_Out    = done_q;
  assign Locked_Out        = (state_q == LOCKED);
  assign Slot_Out          = slot_q;
  assign Sync_Error_Out    = err_q;

endmodule

// File: tb/tb_tdm_demux_1_n.sv
// Scoreboard bench for tdm_demux_1_n: directed beats push expected channel writes, a monitor pops on each output pulse.
module tb_tdm_demux_1_n;

  localparam int unsigned DW = 8;
  localparam int unsigned NC = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             valid = 1'b0;
  logic             sync = 1'b0;
  logic [DW-1:0]    din = '0;
  logic [NC*DW-1:0] ch_data;
  logic [NC-1:0]    ch_valid;
  logic             done;
  logic             locked;
  logic [1:0]       slot;
  logic             err;
`ifdef TDM_DEMUX_ERR_COUNT_EN
  logic [7:0]       err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  typedef struct {
    int          ch;
    logic [DW-1:0] data;
    logic        done;
  } exp_t;

  exp_t sb[$];

  tdm_demux_1_n #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC)) dut (
    .Clock_In          (clk),
    .Reset_N_In        (rst_n),
    .Enable_In         (en),
    .Clear_Error_In    (clr),
    .Data_Valid_In     (valid),
    .Frame_Sync_In     (sync),
    .Data_In           (din),
    .Channel_Data_Out  (ch_data),
    .Channel_Valid_Out (ch_valid),
    .Frame_Done_Out    (done),
    .Locked_Out        (locked),
    .Slot_Out          (slot),
`ifdef TDM_DEMUX_ERR_COUNT_EN
    .Error_Count_Out   (err_cnt),
`endif
    .Sync_Error_Out    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) done_seen++;
      if ((|ch_valid) || done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: valid=%0h done=%0b, expected no output", ch_valid, done);
        end else begin
          e = sb.pop_front();
          chk("mon_valid", 64'(ch_valid), 64'(4'b0001 << e.ch));
          chk("mon_data", 64'(ch_data[e.ch*DW +: DW]), 64'(e.data));
          chk("mon_done", 64'(done), 64'(e.done));
        end
      end
    end
  end

  task automatic beat(input logic [DW-1:0] d, input logic s, input int exp_ch, input logic exp_done);
    exp_t e;
    @(negedge clk);
    en    = 1'b1;
    valid = 1'b1;
    sync  = s;
    din   = d;
    if (exp_ch >= 0) begin
      e.ch   = exp_ch;
      e.data = d;
      e.done = exp_done;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
    sync  = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    valid = 1'b0;
    sync  = 1'b0;
    clr   = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_data", 64'(ch_data), 64'h0);
    chk("rst_valid", 64'(ch_valid), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    chk("rst_slot", 64'(slot), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Beats without sync are discarded while hunting
    beat(8'hAA, 1'b0, -1, 1'b0);
    beat(8'hBB, 1'b0, -1, 1'b0);
    idle();
    chk("hunt_locked", 64'(locked), 64'h0);
    chk("hunt_err", 64'(err), 64'h0);
    chk("hunt_data", 64'(ch_data), 64'h0);

    // Two clean frames
    beat(8'h10, 1'b1, 0, 1'b0);
    beat(8'h11, 1'b0, 1, 1'b0);
    beat(8'h12, 1'b0, 2, 1'b0);
    beat(8'h13, 1'b0, 3, 1'b1);
    beat(8'h20, 1'b1, 0, 1'b0);
    beat(8'h21, 1'b0, 1, 1'b0);
    beat(8'h22, 1'b0, 2, 1'b0);
    beat(8'h23, 1'b0, 3, 1'b1);
    idle();
    chk("frames_data", 64'(ch_data), 64'h23222120);
    chk("frames_done_count", 64'(done_seen), 64'd2);
    chk("frames_locked", 64'(locked), 64'h1);
    chk("frames_err", 64'(err), 64'h0);
    chk("frames_slot", 64'(slot), 64'h0);

    // Early sync at slot 2
    beat(8'h30, 1'b1, 0, 1'b0);
    beat(8'h31, 1'b0, 1, 1'b0);
    beat(8'h55, 1'b1, 0, 1'b0);
    idle();
    chk("early_data", 64'(ch_data), 64'h23223155);
    chk("early_slot", 64'(slot), 64'h1);
    chk("early_err", 64'(err), 64'h1);
    chk("early_locked", 64'(locked), 64'h1);
    chk("early_done_count", 64'(done_seen), 64'd2);
`ifdef TDM_DEMUX_ERR_COUNT_EN
    chk("early_cnt", 64'(err_cnt), 64'd1);
`endif
    clear_err();
    chk("clear1_err", 64'(err), 64'h0);
`ifdef TDM_DEMUX_ERR_COUNT_EN
    chk("clear1_cnt", 64'(err_cnt), 64'd0);
`endif

    // Finish the frame, then a missing sync at slot 0
    beat(8'h61, 1'b0, 1, 1'b0);
    beat(8'h62, 1'b0, 2, 1'b0);
    beat(8'h63, 1'b0, 3, 1'b1);
    beat(8'h77, 1'b0, -1, 1'b0);
    idle();
    chk("miss_locked", 64'(locked), 64'h0);
    chk("miss_err", 64'(err), 64'h1);
    chk("miss_data", 64'(ch_data), 64'h63626155);
    chk("miss_slot", 64'(slot), 64'h0);
    clear_err();
    chk("clear2_err", 64'(err), 64'h0);

    // Enable low mid-frame holds slot and data
    beat(8'h40, 1'b1, 0, 1'b0);
    beat(8'h41, 1'b0, 1, 1'b0);
    @(negedge clk);
    en    = 1'b0;
    valid = 1'b1;
    sync  = 1'b0;
    din   = 8'h99;
    repeat (3) @(negedge clk);
    chk("hold_slot", 64'(slot), 64'h2);
    chk("hold_data", 64'(ch_data), 64'h63624140);
    beat(8'h33, 1'b0, 2, 1'b0);
    beat(8'h44, 1'b0, 3, 1'b1);
    idle();
    chk("resume_data", 64'(ch_data), 64'h44334140);
    chk("resume_slot", 64'(slot), 64'h0);

    // Missing sync together with clear: the error wins
    @(negedge clk);
    en    = 1'b1;
    valid = 1'b1;
    sync  = 1'b0;
    din   = 8'h88;
    clr   = 1'b1;
    idle();
    chk("clr_vs_err_err", 64'(err), 64'h1);
    chk("clr_vs_err_locked", 64'(locked), 64'h0);
`ifdef TDM_DEMUX_ERR_COUNT_EN
    chk("clr_vs_err_cnt", 64'(err_cnt), 64'd1);
`endif

    // Asynchronous reset mid-frame at slot 3
    beat(8'h50, 1'b1, 0, 1'b0);
    beat(8'h51, 1'b0, 1, 1'b0);
    beat(8'h52, 1'b0, 2, 1'b0);
    idle();
    chk("pre_rst_slot", 64'(slot), 64'h3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", 64'(ch_data), 64'h0);
    chk("arst_locked", 64'(locked), 64'h0);
    chk("arst_slot", 64'(slot), 64'h0);
    chk("arst_err", 64'(err), 64'h0);
    chk("arst_valid", 64'(ch_valid), 64'h0);
`ifdef TDM_DEMUX_ERR_COUNT_EN
    chk("arst_cnt", 64'(err_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("post_rst_locked", 64'(locked), 64'h0);
    beat(8'h5A, 1'b0, -1, 1'b0);
    beat(8'h5B, 1'b1, 0, 1'b0);
    idle();
    chk("relock_locked", 64'(locked), 64'h1);
    chk("relock_slot", 64'(slot), 64'h1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
